timer_set_datapath: RTL and testbench

Datapath partner of the timer-set PLA controller in the digital clock/calendar. It consumes the controller's strobes (Kc, La, Lb, Ea, Lr, Er, s) and returns the status inputs the controller branches on (t, k7). It holds a snapshot of the 7 time/date fields, steps the selected field up or down with per-field wrap, and commits the edited set to the clock core through a valid/ack handshake.

---
 rtl/timer_set_datapath_pkg.sv | 50 +++++
 rtl/timer_set_datapath_btn_edge_sync.sv | 29 ++
 rtl/timer_set_datapath.sv | 206 ++++++++++++++++++++
 tb/tb_timer_set_datapath.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_set_datapath_pkg.sv
// Shared constants for the timer-set datapath: field indices, per-field ranges,
// ALU select and pending-button encodings, and the month-length helper.
package timer_set_pkg;

    localparam int W  = 7;
    localparam int NF = 7;

    localparam logic [2:0] F_SEC    = 3'd0;
    localparam logic [2:0] F_MIN    = 3'd1;
    localparam logic [2:0] F_HOUR   = 3'd2;
    localparam logic [2:0] F_DAY    = 3'd3;
    localparam logic [2:0] F_MONTH  = 3'd4;
    localparam logic [2:0] F_YEARLO = 3'd5;
    localparam logic [2:0] F_YEARHI = 3'd6;
    localparam logic [2:0] F_DONE   = 3'd7;

    // Entry 7 covers K==7 so the tables can be indexed directly by K.
    localparam logic [W-1:0] FIELD_MIN [8] = '{7'd0, 7'd0, 7'd0, 7'd1, 7'd1, 7'd0, 7'd0, 7'd0};
    localparam logic [W-1:0] FIELD_MAX [8] = '{7'd59, 7'd59, 7'd23, 7'd31, 7'd12, 7'd99, 7'd99, 7'd0};

    typedef enum logic [1:0] {
        S_PASS = 2'b00,
        S_STEP = 2'b01,
        S_MIN  = 2'b10,
        S_MAX  = 2'b11
    } alu_sel_e;

    typedef enum logic [1:0] {
        BTN_NONE = 2'b00,
        BTN_UP   = 2'b01,
        BTN_DOWN = 2'b10,
        BTN_NEXT = 2'b11
    } btn_code_e;

    function automatic logic [W-1:0] days_in_month(input logic [W-1:0] month,
                                                   input logic [W-1:0] yr_hi,
                                                   input logic [W-1:0] yr_lo);
        logic [13:0] year;
        logic        leap;
        year = 14'(yr_hi) * 14'd100 + 14'(yr_lo);
        leap = (year[1:0] == 2'b00) &&
               (((year % 14'd100) != 14'd0) || ((year % 14'd400) == 14'd0));
        case (month)
            7'd4, 7'd6, 7'd9, 7'd11: return 7'd30;
            7'd2:                    return leap ? 7'd29 : 7'd28;
            default:                 return 7'd31;
        endcase
    endfunction

endpackage

// File: rtl/timer_set_datapath_btn_edge_sync.sv
// Two-flop synchronizer for an asynchronous button, followed by a rising-edge
// pulse (one clk wide) on the synchronized level.
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus a delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/timer_set_datapath.sv
// Timer-set datapath: field snapshot, per-field up/down ALU, button capture and
// commit handshake. Define TIMER_SET_MONTH_DAYS_EN for month/leap-aware day limits.
module timer_set_datapath
    import timer_set_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_next,
    input  logic            btn_up,
    input  logic            btn_down,
    input  logic            Kc,
    input  logic            La,
    input  logic            Lb,
    input  logic            Ea,
    input  logic            Lr,
    input  logic            Er,
    input  logic [1:0]      s,
    input  logic [NF*W-1:0] time_in,
    input  logic            set_ack,
    output logic            t,
    output logic            k7,
    output logic [2:0]      cur_field,
    output logic [W-1:0]    cur_val,
    output logic [NF*W-1:0] set_out,
    output logic            set_valid
);

    logic          w_rise_next;
    logic          w_rise_up;
    logic          w_rise_down;
    btn_code_e     w_new_code;
    btn_code_e     w_pend_base;
    logic [W-1:0]  w_field_k;
    logic [W-1:0]  w_la_val;
    logic [W-1:0]  w_min;
    logic [W-1:0]  w_max;
    logic [W-1:0]  w_a_cl;
    logic [W-1:0]  w_alu;

    logic [2:0]    r_k;
    logic [W-1:0]  r_a;
    btn_code_e     r_b;
    logic [W-1:0]  r_r;
    logic [W-1:0]  r_field [NF];
    btn_code_e     r_pending;
    logic          r_t;
    logic          r_commit;
    logic          r_set_valid;

    btn_edge_sync u_sync_next (.clk(clk), .rst(rst), .i_btn(btn_next), .o_rise(w_rise_next));
    btn_edge_sync u_sync_up   (.clk(clk), .rst(rst), .i_btn(btn_up),   .o_rise(w_rise_up));
    btn_edge_sync u_sync_down (.clk(clk), .rst(rst), .i_btn(btn_down), .o_rise(w_rise_down));

    // Encode simultaneous edges by priority; Lb clears pending before capture.
    always_comb begin
        w_new_code = BTN_NONE;
        if (w_rise_next) begin
            w_new_code = BTN_NEXT;
        end else if (w_rise_up) begin
            w_new_code = BTN_UP;
        end else if (w_rise_down) begin
            w_new_code = BTN_DOWN;
        end else begin
            w_new_code = BTN_NONE;
        end
        w_pend_base = Lb ? BTN_NONE : r_pending;
    end

    // Select field[K]; K==7 reads as zero.
    always_comb begin
        w_field_k = 7'd0;
        case (r_k)
            F_SEC:    w_field_k = r_field[0];
            F_MIN:    w_field_k = r_field[1];
            F_HOUR:   w_field_k = r_field[2];
            F_DAY:    w_field_k = r_field[3];
            F_MONTH:  w_field_k = r_field[4];
            F_YEARLO: w_field_k = r_field[5];
            F_YEARHI: w_field_k = r_field[6];
            default:  w_field_k = 7'd0;
        endcase
    end

    // Range limits for the current field, and the load value for La.
    always_comb begin
        w_min    = FIELD_MIN[r_k];
        w_max    = FIELD_MAX[r_k];
        w_la_val = w_field_k;
`ifdef TIMER_SET_MONTH_DAYS_EN
        if (r_k == F_DAY) begin
            w_max = days_in_month(r_field[4], r_field[6], r_field[5]);
        end else begin
            w_max = FIELD_MAX[r_k];
        end
        if ((r_k == F_DAY) && (w_field_k > w_max)) begin
            w_la_val = w_max;
        end else begin
            w_la_val = w_field_k;
        end
`endif
        w_a_cl = (r_a > w_max) ? w_max : r_a;
    end

    // ALU: pass, wrap-around step, or field limits.
    always_comb begin
        w_alu = w_a_cl;
        case (alu_sel_e'(s))
            S_PASS: w_alu = w_a_cl;
            S_STEP: begin
                case (r_b)
                    BTN_UP:   w_alu = (w_a_cl >= w_max) ? w_min : w_a_cl + 7'd1;
                    BTN_DOWN: w_alu = (w_a_cl <= w_min) ? w_max : w_a_cl - 7'd1;
                    default:  w_alu = w_a_cl;
                endcase
            end
            S_MIN:  w_alu = w_min;
            S_MAX:  w_alu = w_max;
            default: w_alu = w_a_cl;
        endcase
    end

    // Working registers A/B/R, field file and field counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k <= 3'd0;
            r_a <= 7'd0;
            r_b <= BTN_NONE;
            r_r <= 7'd0;
            for (int i = 0; i < NF; i++) begin
                r_field[i] <= 7'd0;
            end
        end else begin
            if (Lb) begin
                r_b <= r_pending;
            end
            if (La) begin
                r_a <= w_la_val;
            end else if (Ea) begin
                r_a <= r_r;
            end
            if (Lr) begin
                r_r <= w_alu;
            end
            if (Kc) begin
                r_k <= 3'd0;
                for (int i = 0; i < NF; i++) begin
                    r_field[i] <= time_in[i*W +: W];
                end
            end else if (Er && (r_k != F_DONE)) begin
                r_k <= r_k + 3'd1;
                for (int i = 0; i < NF; i++) begin
                    if (r_k == 3'(i)) begin
                        r_field[i] <= r_r;
                    end
                end
            end
        end
    end

    // Button capture: one pending code at a time, t marks each acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= BTN_NONE;
            r_t       <= 1'b0;
        end else begin
            if ((w_new_code != BTN_NONE) && (w_pend_base == BTN_NONE)) begin
                r_pending <= w_new_code;
                r_t       <= 1'b1;
            end else begin
                r_pending <= w_pend_base;
                r_t       <= 1'b0;
            end
        end
    end

    // Commit request raised one cycle after the last field is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_commit    <= 1'b0;
            r_set_valid <= 1'b0;
        end else begin
            r_commit <= ~Kc & Er & (r_k == F_YEARHI);
            if (Kc) begin
                r_set_valid <= 1'b0;
            end else if (r_commit) begin
                r_set_valid <= 1'b1;
            end else if (r_set_valid && set_ack) begin
                r_set_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        set_out = '0;
        for (int i = 0; i < NF; i++) begin
            set_out[i*W +: W] = r_field[i];
        end
    end

    assign t         = r_t;
    assign k7        = (r_k == F_DONE);
    assign cur_field = r_k;
    assign cur_val   = r_a;
    assign set_valid = r_set_valid;

endmodule

// File: tb/tb_timer_set_datapath.sv
// Randomized self-checking bench for timer_set_datapath with a behavioural model
// of fields, A/B/R, K and the pending button code.
module tb_timer_set_datapath;

    logic        clk = 1'b0;
    logic        rst, btn_next, btn_up, btn_down;
    logic        Kc, La, Lb, Ea, Lr, Er, set_ack;
    logic [1:0]  s;
    logic [48:0] time_in;
    logic        t, k7, set_valid;
    logic [2:0]  cur_field;
    logic [6:0]  cur_val;
    logic [48:0] set_out;

    int n_checks = 0;
    int n_fail   = 0;
    int t_cnt    = 0;

    int tf [7];
    int mf [7];
    int mk, ma, mb, mr, mpend;

    timer_set_datapath dut (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
        .Kc(Kc), .La(La), .Lb(Lb), .Ea(Ea), .Lr(Lr), .Er(Er), .s(s),
        .time_in(time_in), .set_ack(set_ack), .t(t), .k7(k7), .cur_field(cur_field),
        .cur_val(cur_val), .set_out(set_out), .set_valid(set_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (t === 1'b1) t_cnt++;

    // ---------------- reference model ----------------
    function automatic int fmin(int k);
        return (k == 3 || k == 4) ? 1 : 0;
    endfunction

    function automatic int dim(int m, int y);
        bit leap;
        leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        if (m == 2) return leap ? 29 : 28;
        return 31;
    endfunction

    function automatic int fmax(int k);
        case (k)
            0, 1: return 59;
            2:    return 23;
`ifdef TIMER_SET_MONTH_DAYS_EN
            3:    return dim(mf[4], mf[6] * 100 + mf[5]);
`else
            3:    return 31;
`endif
            4:    return 12;
            5, 6: return 99;
            default: return 0;
        endcase
    endfunction

    function automatic int model_alu(int sel);
        int lo, hi, a, span;
        lo = fmin(mk); hi = fmax(mk); a = (ma > hi) ? hi : ma;
        span = hi - lo + 1;
        case (sel)
            0: return a;
            1: begin
                if (mb == 1) return lo + (a - lo + 1) % span;
                if (mb == 2) return lo + (a - lo - 1 + span) % span;
                return a;
            end
            2: return lo;
            default: return hi;
        endcase
    endfunction

    function automatic int model_la();
        int v;
        if (mk == 7) return 0;
        v = mf[mk];
`ifdef TIMER_SET_MONTH_DAYS_EN
        if (mk == 3 && v > fmax(3)) v = fmax(3);
`endif
        return v;
    endfunction

    function automatic logic [48:0] pack_tf();
        logic [48:0] p = '0;
        for (int i = 0; i < 7; i++) p[i*7 +: 7] = 7'(tf[i]);
        return p;
    endfunction

    function automatic logic [48:0] pack_mf();
        logic [48:0] p = '0;
        for (int i = 0; i < 7; i++) p[i*7 +: 7] = 7'(mf[i]);
        return p;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rnd_time();
        for (int i = 0; i < 7; i++) tf[i] = fmin(i) + $urandom_range(0, (i == 3) ? 30 : (fmax(i) - fmin(i)));
        tf[4] = $urandom_range(1, 12);
        time_in = pack_tf();
    endtask

    task automatic op(bit kc, bit la, bit lb, bit ea, bit lr, bit er, int sel);
        int rr, ok, av, lv;
        rr = mr; ok = mk; av = model_alu(sel); lv = model_la();
        Kc = kc; La = la; Lb = lb; Ea = ea; Lr = lr; Er = er; s = 2'(sel);
        cyc(1);
        Kc = 0; La = 0; Lb = 0; Ea = 0; Lr = 0; Er = 0; s = 2'b00;
        if (lb) begin mb = mpend; mpend = 0; end
        if (la) ma = lv; else if (ea) ma = rr;
        if (lr) mr = av;
        if (kc) begin mk = 0; mf = tf; end
        else if (er && ok < 7) begin mf[ok] = rr; mk = ok + 1; end
    endtask

    task automatic press(int code);
        btn_up = (code == 1); btn_down = (code == 2); btn_next = (code == 3);
        cyc(3);
        btn_up = 0; btn_down = 0; btn_next = 0;
        cyc(4);
        if (mpend == 0) mpend = code;
    endtask

    task automatic model_reset();
        mk = 0; ma = 0; mb = 0; mr = 0; mpend = 0;
        for (int i = 0; i < 7; i++) mf[i] = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1; cyc(2);
        n_checks++; if (t !== 1'b0) begin n_fail++; $display("FAIL reset_t: got %b expected 0", t); end
        n_checks++; if (k7 !== 1'b0) begin n_fail++; $display("FAIL reset_k7: got %b expected 0", k7); end
        n_checks++; if (cur_field !== 3'd0 || cur_val !== 7'd0) begin n_fail++; $display("FAIL reset_k_a: got %0d/%0d expected 0/0", cur_field, cur_val); end
        n_checks++; if (set_out !== 49'd0 || set_valid !== 1'b0) begin n_fail++; $display("FAIL reset_commit: got %h/%b expected 0/0", set_out, set_valid); end
        rst = 0; model_reset(); cyc(1);
    endtask

    task automatic test_sec_wrap();
        int t0;
        rnd_time(); tf[0] = 59; time_in = pack_tf();
        op(1,0,0,0,0,0,0);
        n_checks++; if (set_out !== pack_tf()) begin n_fail++; $display("FAIL kc_snapshot: got %h expected %h", set_out, pack_tf()); end
        op(0,1,0,0,0,0,0);
        n_checks++; if (cur_val !== 7'd59) begin n_fail++; $display("FAIL la_sec: got %0d expected 59", cur_val); end
        t0 = t_cnt; press(1);
        n_checks++; if (t_cnt - t0 != 1) begin n_fail++; $display("FAIL up_t_pulse: got %0d pulses expected 1", t_cnt - t0); end
        op(0,0,1,0,0,0,0); op(0,0,0,0,1,0,1); op(0,0,0,1,0,0,0);
        n_checks++; if (cur_val !== 7'd0) begin n_fail++; $display("FAIL sec_up_wrap: got %0d expected 0", cur_val); end
        press(2); op(0,0,1,0,0,0,0); op(0,0,0,0,1,0,1); op(0,0,0,1,0,0,0);
        n_checks++; if (cur_val !== 7'd59) begin n_fail++; $display("FAIL sec_down_wrap: got %0d expected 59", cur_val); end
    endtask

    task automatic test_day_wrap();
        int exp_max;
`ifdef TIMER_SET_MONTH_DAYS_EN
        exp_max = 28;
`else
        exp_max = 31;
`endif
        rnd_time(); tf[3] = 1; tf[4] = 2; tf[5] = 23; tf[6] = 20; time_in = pack_tf();
        op(1,0,0,0,0,0,0);
        repeat (3) begin op(0,1,0,0,0,0,0); op(0,0,0,0,1,0,0); op(0,0,0,0,0,1,0); end
        op(0,1,0,0,0,0,0);
        n_checks++; if (cur_field !== 3'd3 || cur_val !== 7'd1) begin n_fail++; $display("FAIL day_load: got K=%0d A=%0d expected K=3 A=1", cur_field, cur_val); end
        press(2); op(0,0,1,0,0,0,0); op(0,0,0,0,1,0,1); op(0,0,0,1,0,0,0);
        n_checks++; if (cur_val !== 7'(exp_max)) begin n_fail++; $display("FAIL day_down_wrap: got %0d expected %0d", cur_val, exp_max); end
        op(0,0,0,0,1,0,2); op(0,0,0,1,0,0,0);
        n_checks++; if (cur_val !== 7'd1) begin n_fail++; $display("FAIL day_min: got %0d expected 1", cur_val); end
        op(0,0,0,0,1,0,3); op(0,0,0,1,0,0,0);
        n_checks++; if (cur_val !== 7'(exp_max)) begin n_fail++; $display("FAIL day_max: got %0d expected %0d", cur_val, exp_max); end
    endtask

    task automatic test_random_edit();
        logic [48:0] held;
        for (int it = 0; it < 3; it++) begin
            rnd_time(); op(1,0,0,0,0,0,0);
            for (int k = 0; k < 7; k++) begin
                op(0,1,0,0,0,0,0);
                n_checks++; if (cur_val !== 7'(ma)) begin n_fail++; $display("FAIL rand_la k=%0d: got %0d expected %0d", k, cur_val, ma); end
                repeat ($urandom_range(0, 3)) begin
                    press(($urandom_range(0, 7) == 0) ? 3 : $urandom_range(1, 2));
                    op(0,0,1,0,0,0,0); op(0,0,0,0,1,0,1); op(0,0,0,1,0,0,0);
                    n_checks++; if (cur_val !== 7'(ma)) begin n_fail++; $display("FAIL rand_step k=%0d: got %0d expected %0d", k, cur_val, ma); end
                end
                op(0,0,0,0,1,0,($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : 0);
                op(0,0,0,0,0,1,0);
            end
            n_checks++; if (k7 !== 1'b1 || set_valid !== 1'b0) begin n_fail++; $display("FAIL done_k7: got k7=%b valid=%b expected 1/0", k7, set_valid); end
            cyc(1);
            held = pack_mf();
            n_checks++; if (set_valid !== 1'b1 || set_out !== held) begin n_fail++; $display("FAIL commit: got valid=%b out=%h expected 1/%h", set_valid, set_out, held); end
            repeat ($urandom_range(1, 4)) begin
                cyc(1);
                n_checks++; if (set_valid !== 1'b1 || set_out !== held) begin n_fail++; $display("FAIL commit_hold: got valid=%b out=%h expected 1/%h", set_valid, set_out, held); end
            end
            set_ack = 1; cyc(1); set_ack = 0;
            n_checks++; if (set_valid !== 1'b0) begin n_fail++; $display("FAIL ack_clear: got %b expected 0", set_valid); end
            op(0,0,0,0,0,1,0); op(0,1,0,0,0,0,0);
            n_checks++; if (cur_field !== 3'd7 || cur_val !== 7'd0) begin n_fail++; $display("FAIL k_saturate: got K=%0d A=%0d expected 7/0", cur_field, cur_val); end
        end
    endtask

    task automatic test_buttons();
        int t0;
        rnd_time(); op(1,0,0,0,0,0,0); op(0,1,0,0,0,0,0);
        t0 = t_cnt;
        btn_up = 1; btn_next = 1; cyc(6); btn_up = 0; btn_next = 0; cyc(3);
        if (mpend == 0) mpend = 3;
        n_checks++; if (t_cnt - t0 != 1) begin n_fail++; $display("FAIL simul_t: got %0d pulses expected 1", t_cnt - t0); end
        t0 = t_cnt; press(1);
        n_checks++; if (t_cnt - t0 != 0) begin n_fail++; $display("FAIL dropped_t: got %0d pulses expected 0", t_cnt - t0); end
        op(0,0,1,0,0,0,0); op(0,0,0,0,1,0,1); op(0,0,0,1,0,0,0);
        n_checks++; if (cur_val !== 7'(ma) || ma != mf[0]) begin n_fail++; $display("FAIL next_priority: got %0d expected %0d", cur_val, mf[0]); end
        press(2);
        t0 = t_cnt;
        btn_up = 1; cyc(2); op(0,0,1,0,0,0,0);
        mpend = 1;
        cyc(3); btn_up = 0; cyc(2);
        n_checks++; if (t_cnt - t0 != 1) begin n_fail++; $display("FAIL lb_overlap_t: got %0d pulses expected 1", t_cnt - t0); end
        op(0,0,1,0,0,0,0); op(0,0,0,0,1,0,1); op(0,0,0,1,0,0,0);
        n_checks++; if (cur_val !== 7'(ma)) begin n_fail++; $display("FAIL lb_overlap_step: got %0d expected %0d", cur_val, ma); end
    endtask

    task automatic test_kc_er();
        rnd_time(); op(1,0,0,0,0,0,0);
        repeat (4) begin op(0,1,0,0,0,0,0); op(0,0,0,0,1,0,0); op(0,0,0,0,0,1,0); end
        n_checks++; if (cur_field !== 3'd4) begin n_fail++; $display("FAIL advance_k4: got %0d expected 4", cur_field); end
        rnd_time(); op(1,0,0,0,0,1,0);
        n_checks++; if (cur_field !== 3'd0 || set_out !== pack_tf()) begin n_fail++; $display("FAIL kc_over_er: got K=%0d out=%h expected 0/%h", cur_field, set_out, pack_tf()); end
        op(0,1,0,0,0,0,0);
        n_checks++; if (cur_val !== 7'(tf[0])) begin n_fail++; $display("FAIL kc_la: got %0d expected %0d", cur_val, tf[0]); end
    endtask

    task automatic test_async_reset();
        op(0,0,0,0,1,0,3); op(0,0,0,0,0,1,0); op(0,1,0,0,0,0,0);
        #2 rst = 1; #1;
        n_checks++; if (cur_field !== 3'd0 || cur_val !== 7'd0 || k7 !== 1'b0) begin n_fail++; $display("FAIL async_rst_k_a: got K=%0d A=%0d k7=%b expected 0/0/0", cur_field, cur_val, k7); end
        n_checks++; if (set_out !== 49'd0 || set_valid !== 1'b0 || t !== 1'b0) begin n_fail++; $display("FAIL async_rst_out: got %h/%b/%b expected 0/0/0", set_out, set_valid, t); end
        cyc(2); rst = 0; model_reset(); cyc(1);
    endtask

    initial begin
        rst = 1; btn_next = 0; btn_up = 0; btn_down = 0;
        Kc = 0; La = 0; Lb = 0; Ea = 0; Lr = 0; Er = 0; s = 2'b00;
        time_in = '0; set_ack = 0;
        model_reset();
        for (int i = 0; i < 7; i++) tf[i] = 0;
        test_reset();
        test_sec_wrap();
        test_day_wrap();
        test_random_edit();
        test_buttons();
        test_kc_er();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
